// File: rtl/led_display_ctrl.sv
// Purpose: 4-digit multiplexed 7-segment controller with a two-writer round-robin
//          display register, blanking-gapped digit scan and per-digit blank/blink masks.
// Latency: a write granted on edge k shows on disp_value after edge k, with gnt high
//          during cycle k+1. digit and enable_segments are registered from the state
//          that holds at each edge. Backpressure: a requester holds req/data until its
//          one-cycle gnt. It is not eligible again while its own gnt is high.
//
// Ports:
//   clk, rst           : single clock, synchronous active-high reset
//   req0/data0/gnt0    : CPU write port (16-bit display value)
//   req1/data1/gnt1    : debug monitor write port (16-bit display value)
//   cfg_we/cfg_data    : mask load; [3:0] blank mask, [7:4] blink mask (bit i = digit i)
//   digit              : nibble of the scanned digit, to the hex-to-segment decoder
//   enable_segments    : active-low one-hot digit commons
//   disp_value         : display register readback

module led_display_ctrl #(
    parameter int unsigned DWELL      = 16,  // cycles each digit is lit per slot (>=1)
    parameter int unsigned GAP        = 2,   // all-off cycles after each slot (>=1)
    parameter int unsigned BLINK_BITS = 20   // blink counter width; MSB is blink phase
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt1,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_data,
    output logic [3:0]  digit,
    output logic [3:0]  enable_segments,
    output logic [15:0] disp_value
);

    // The scan counter is shared by the ON and GAP phases, so it is sized for
    // the longer of the two.
    localparam int unsigned CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_GAP = 1'b1
    } phase_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  ptr_q, ptr_d;        // 0: req0 has priority, 1: req1
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic [15:0]           disp_q, disp_d;
    logic [3:0]            blank_q, blank_d;
    logic [3:0]            blink_q, blink_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;

    phase_e                phase_q, phase_d;
    logic [1:0]            idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [3:0]            en_q, en_d;
    logic [3:0]            digit_q, digit_d;

    // ------------------------------------------------------------------
    // Round-robin arbiter and display register
    // ------------------------------------------------------------------
    logic elig0, elig1;
    logic win0, win1;

    // A requester whose grant is still showing is not eligible. This stops a
    // held request from being granted again before the requester has seen the
    // ack, and it limits each port to one grant every two cycles.
    assign elig0 = req0 & ~gnt0_q;
    assign elig1 = req1 & ~gnt1_q;

    assign win0  = elig0 & (~elig1 | ~ptr_q);
    assign win1  = elig1 & (~elig0 |  ptr_q);

    always_comb begin
        ptr_d  = ptr_q;
        disp_d = disp_q;
        gnt0_d = win0;
        gnt1_d = win1;
        if (win0) begin
            disp_d = data0;
            ptr_d  = 1'b1;
        end else if (win1) begin
            disp_d = data1;
            ptr_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Configuration masks and blink counter
    // ------------------------------------------------------------------
    always_comb begin
        blank_d     = blank_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        if (cfg_we) begin
            blank_d = cfg_data[3:0];
            blink_d = cfg_data[7:4];
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: ON for DWELL cycles, then GAP for GAP cycles, then next digit
    // ------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        unique case (phase_q)
            PH_ON: begin
                if (cnt_q == DWELL_LAST) begin
                    phase_d = PH_GAP;
                    cnt_d   = '0;
                end
            end
            PH_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    phase_d = PH_ON;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;   // 3 wraps to 0
                end
            end
            default: begin
                phase_d = PH_ON;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage, computed from the state that holds at this edge
    // ------------------------------------------------------------------
    logic blink_phase;
    logic lit;

    assign blink_phase = blink_cnt_q[BLINK_BITS-1];

    always_comb begin
        lit = (phase_q == PH_ON)
              && !blank_q[idx_q]
              && !(blink_q[idx_q] && blink_phase);
        en_d = 4'b1111;
        if (lit) begin
            en_d[idx_q] = 1'b0;
        end
        // Uses the pre-write register, so a new value reaches digit one edge
        // after it lands in disp_value.
        digit_d = disp_q[{idx_q, 2'b00} +: 4];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            disp_q      <= '0;
            blank_q     <= '0;
            blink_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= PH_ON;
            idx_q       <= '0;
            cnt_q       <= '0;
            en_q        <= 4'b1111;
            digit_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            disp_q      <= disp_d;
            blank_q     <= blank_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            digit_q     <= digit_d;
        end
    end

    assign gnt0            = gnt0_q;
    assign gnt1            = gnt1_q;
    assign disp_value      = disp_q;
    assign enable_segments = en_q;
    assign digit           = digit_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Purpose: directed, table-driven bench for led_display_ctrl (DWELL=4, GAP=1, BLINK_BITS=6).
// Latency: each table row drives inputs before an edge and expects the outputs just after it.
// Backpressure: requesters in the rows drop req once their gnt is seen, unless a row holds it on purpose.

module tb_led_display_ctrl;

    localparam int unsigned DW = 4;
    localparam int unsigned GP = 1;
    localparam int unsigned BB = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic [15:0] data0 = '0;
    logic        req1 = 1'b0;
    logic [15:0] data1 = '0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_data = '0;
    logic        gnt0, gnt1;
    logic [3:0]  digit, enable_segments;
    logic [15:0] disp_value;

    led_display_ctrl #(.DWELL(DW), .GAP(GP), .BLINK_BITS(BB)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (req0),
        .data0           (data0),
        .gnt0            (gnt0),
        .req1            (req1),
        .data1           (data1),
        .gnt1            (gnt1),
        .cfg_we          (cfg_we),
        .cfg_data        (cfg_data),
        .digit           (digit),
        .enable_segments (enable_segments),
        .disp_value      (disp_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        q0;
        logic [15:0] d0;
        logic        q1;
        logic [15:0] d1;
        logic        we;
        logic [7:0]  cf;
        int          n;      // number of consecutive edges this row applies to
        logic        g0;
        logic        g1;
        logic [3:0]  en;
        logic [3:0]  dg;
        logic [15:0] dv;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, input logic q0, input logic [15:0] d0,
                       input logic q1, input logic [15:0] d1,
                       input logic we, input logic [7:0] cf, input int n,
                       input logic g0, input logic g1, input logic [3:0] en,
                       input logic [3:0] dg, input logic [15:0] dv);
        vec_t v;
        v.r = r; v.q0 = q0; v.d0 = d0; v.q1 = q1; v.d1 = d1;
        v.we = we; v.cf = cf; v.n = n;
        v.g0 = g0; v.g1 = g1; v.en = en; v.dg = dg; v.dv = dv;
        vq.push_back(v);
    endtask

    task automatic idle(input int n, input logic [3:0] en, input logic [3:0] dg,
                        input logic [15:0] dv);
        add(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00, n, 1'b0, 1'b0, en, dg, dv);
    endtask

    task automatic rst_row();
        add(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 4'hF, 4'h0, 16'h0);
    endtask

    // One idle frame with digit 0 and disp_value at 0. Slot 0 shows en0.
    task automatic frame(input logic [3:0] en0);
        idle(4, en0,  4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        idle(4, 4'hD, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        idle(4, 4'hB, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        idle(4, 4'h7, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic g0, input logic g1,
                           input logic [3:0] en, input logic [3:0] dg, input logic [15:0] dv);
        chk({tag, ".gnt0"},   {15'h0, gnt0}, {15'h0, g0});
        chk({tag, ".gnt1"},   {15'h0, gnt1}, {15'h0, g1});
        chk({tag, ".enable"}, {12'h0, enable_segments}, {12'h0, en});
        chk({tag, ".digit"},  {12'h0, digit}, {12'h0, dg});
        chk({tag, ".disp"},   disp_value, dv);
    endtask

    task automatic drive(input logic r, input logic q0, input logic [15:0] d0,
                         input logic q1, input logic [15:0] d1,
                         input logic we, input logic [7:0] cf);
        rst = r; req0 = q0; data0 = d0; req1 = q1; data1 = d1; cfg_we = we; cfg_data = cf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- A: reset release with no traffic, two full frames ----
        rst_row();
        rst_row();
        frame(4'hE);
        frame(4'hE);

        // ---- B: single CPU write of 0x1234, then one scan frame ----
        rst_row();
        add(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 8'h00, 1, 1'b1, 1'b0, 4'hE, 4'h0, 16'h1234);
        idle(3, 4'hE, 4'h4, 16'h1234); idle(1, 4'hF, 4'h4, 16'h1234);
        idle(4, 4'hD, 4'h3, 16'h1234); idle(1, 4'hF, 4'h3, 16'h1234);
        idle(4, 4'hB, 4'h2, 16'h1234); idle(1, 4'hF, 4'h2, 16'h1234);
        idle(4, 4'h7, 4'h1, 16'h1234); idle(1, 4'hF, 4'h1, 16'h1234);
        idle(1, 4'hE, 4'h4, 16'h1234);

        // ---- C: both requesters held, grants alternate starting with req0 ----
        rst_row();
        add(1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b0, 8'h00, 1, 1'b1, 1'b0, 4'hE, 4'h0, 16'hAAAA);
        add(1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b0, 8'h00, 1, 1'b0, 1'b1, 4'hE, 4'hA, 16'h5555);
        add(1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b0, 8'h00, 1, 1'b1, 1'b0, 4'hE, 4'h5, 16'hAAAA);
        add(1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b0, 8'h00, 1, 1'b0, 1'b1, 4'hE, 4'hA, 16'h5555);
        add(1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b0, 8'h00, 1, 1'b1, 1'b0, 4'hF, 4'h5, 16'hAAAA);
        idle(1, 4'hD, 4'hA, 16'hAAAA);

        // ---- D: blank digit 2, written on the first ON edge of slot 2 together
        //         with a debug write; the old mask still applies on that edge ----
        rst_row();
        idle(4, 4'hE, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        idle(4, 4'hD, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        add(1'b0, 1'b0, 16'h0, 1'b1, 16'h9876, 1'b1, 8'h04, 1, 1'b0, 1'b1, 4'hB, 4'h0, 16'h9876);
        idle(4, 4'hF, 4'h8, 16'h9876);
        idle(4, 4'h7, 4'h9, 16'h9876); idle(1, 4'hF, 4'h9, 16'h9876);
        idle(4, 4'hE, 4'h6, 16'h9876);

        // ---- E: blink digit 0; blink phase is high for edges 33..64 after reset ----
        rst_row();
        add(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 8'h10, 1, 1'b0, 1'b0, 4'hE, 4'h0, 16'h0);
        idle(3, 4'hE, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        idle(4, 4'hD, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        idle(4, 4'hB, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        idle(4, 4'h7, 4'h0, 16'h0); idle(1, 4'hF, 4'h0, 16'h0);
        frame(4'hE);   // edges 21..40
        frame(4'hF);   // edges 41..60
        frame(4'hF);   // edges 61..80
        idle(4, 4'hE, 4'h0, 16'h0);  // edges 81..84, blink phase low again

        foreach (vq[i]) begin
            for (int k = 0; k < vq[i].n; k++) begin
                drive(vq[i].r, vq[i].q0, vq[i].d0, vq[i].q1, vq[i].d1, vq[i].we, vq[i].cf);
                step();
                chk_all($sformatf("row%0d.%0d", i, k),
                        vq[i].g0, vq[i].g1, vq[i].en, vq[i].dg, vq[i].dv);
            end
        end

        // ---- F: reset mid-ON of digit 2 while gnt1 is high and a CPU write is pending ----
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
        repeat (10) step();
        drive(1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 8'h00);
        step();
        chk_all("midrst.grant", 1'b0, 1'b1, 4'hB, 4'h0, 16'hBEEF);
        drive(1'b1, 1'b1, 16'h1111, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        chk_all("midrst.reset", 1'b0, 1'b0, 4'hF, 4'h0, 16'h0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        chk_all("midrst.restart", 1'b0, 1'b0, 4'hE, 4'h0, 16'h0);

        // ---- G: held single request is re-granted only every other edge;
        //         the pointer then favours req1 ----
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b1, 16'h0F0F, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        chk("hold.g1st", {15'h0, gnt0}, 16'h1);
        chk("hold.d1st", disp_value, 16'h0F0F);
        drive(1'b0, 1'b1, 16'h7777, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        chk("hold.gap", {15'h0, gnt0}, 16'h0);
        chk("hold.dgap", disp_value, 16'h0F0F);
        step();
        chk("hold.g2nd", {15'h0, gnt0}, 16'h1);
        chk("hold.d2nd", disp_value, 16'h7777);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        chk("hold.drop", {15'h0, gnt0}, 16'h0);
        drive(1'b0, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 8'h00);
        step();
        chk("ptr.gnt1", {15'h0, gnt1}, 16'h1);
        chk("ptr.gnt0", {15'h0, gnt0}, 16'h0);
        chk("ptr.disp", disp_value, 16'h2222);
        drive(1'b0, 1'b1, 16'h1111, 1'b0, 16'h0, 1'b0, 8'h00);
        step();
        chk("ptr.next", {15'h0, gnt0}, 16'h1);
        chk("ptr.ndisp", disp_value, 16'h1111);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
